// File: rtl/multicycle_ctrl_fsm_pkg.sv
// +----------------------------------------------------------------------+
// | multicycle_ctrl_fsm_pkg : states, opcodes, mux codes, output decode   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package multicycle_ctrl_fsm_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXEC_R   = 4'd7,
      S_EXEC_I   = 4'd8,
      S_ALUWB    = 4'd9,
      S_BEQ      = 4'd10,
      S_JAL      = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;
   localparam logic [1:0] RES_ALUREG = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;
   localparam logic [1:0] IMM_I      = 2'b00;
   localparam logic [1:0] IMM_S      = 2'b01;
   localparam logic [1:0] IMM_B      = 2'b10;
   localparam logic [1:0] IMM_J      = 2'b11;

   typedef struct packed {
      logic       mem_req;
      logic       adr_src;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
   } ctrl_out_t;

   // Pure Moore decode; input-gated enables are formed in the FSM itself.
   function automatic ctrl_out_t state_outputs(state_t s);
      ctrl_out_t o;
      o = '0;
      case (s)
         S_FETCH: begin
            o.mem_req    = 1'b1;
            o.alu_src_a  = SRCA_PC;
            o.alu_src_b  = SRCB_FOUR;
            o.alu_op     = ALUOP_ADD;
            o.result_src = RES_ALU;
         end
         S_DECODE: begin
            o.alu_src_a = SRCA_OLDPC;
            o.alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            o.alu_src_a = SRCA_RS1;
            o.alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            o.mem_req    = 1'b1;
            o.adr_src    = 1'b1;
            o.result_src = RES_ALUREG;
         end
         S_MEMWB: begin
            o.result_src = RES_MEM;
            o.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            o.mem_req   = 1'b1;
            o.mem_write = 1'b1;
            o.adr_src   = 1'b1;
         end
         S_EXEC_R: begin
            o.alu_src_a = SRCA_RS1;
            o.alu_src_b = SRCB_RS2;
            o.alu_op    = ALUOP_FUNC;
         end
         S_EXEC_I: begin
            o.alu_src_a = SRCA_RS1;
            o.alu_src_b = SRCB_IMM;
            o.alu_op    = ALUOP_FUNC;
         end
         S_ALUWB: begin
            o.reg_write = 1'b1;
         end
         S_BEQ: begin
            o.alu_src_a = SRCA_RS1;
            o.alu_src_b = SRCB_RS2;
            o.alu_op    = ALUOP_SUB;
         end
         S_JAL: begin
            o.alu_src_a = SRCA_OLDPC;
            o.alu_src_b = SRCB_FOUR;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
// +----------------------------------------------------------------------+
// | ctrl_wait_timer : memory wait counter with timeout detect            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module ctrl_wait_timer #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wait_en,
   input  logic mem_ready,
   output logic timeout
);

   localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] count_q;
   logic [TO_W-1:0] count_d;

   // Fires in the cycle the count would reach TIMEOUT_CYCLES; a same-cycle ready wins.
   assign timeout = wait_en && !mem_ready && (count_q == LAST_WAIT);

   always_comb begin
      count_d = count_q;
      if (!wait_en || mem_ready || timeout) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// +----------------------------------------------------------------------+
// | multicycle_ctrl_fsm : RV32I multicycle control FSM with mem handshake |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module multicycle_ctrl_fsm
   import multicycle_ctrl_fsm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic [1:0] imm_src,
   output logic       illegal_op,
   output logic       mem_timeout
);

   state_t    state_q;
   state_t    state_d;
   ctrl_out_t out_q;
   ctrl_out_t out_d;
   logic      timeout;
   logic      legal_op;

   ctrl_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .wait_en   (out_q.mem_req),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   always_comb begin
      legal_op = 1'b1;
      state_d  = state_q;
      case (state_q)
         S_IDLE:     state_d = S_FETCH;
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC_R;
               OP_I:         state_d = S_EXEC_I;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  legal_op = 1'b0;
                  state_d  = S_FETCH;
               end
            endcase
         end
         S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXEC_R:   state_d = S_ALUWB;
         S_EXEC_I:   state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         default:    state_d = S_IDLE;
      endcase
      // An abandoned access (fetch included) restarts from the same PC.
      if (timeout) begin
         state_d = S_FETCH;
      end
      out_d = state_outputs(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      imm_src = IMM_I;
      case (opcode)
         OP_SW:   imm_src = IMM_S;
         OP_BEQ:  imm_src = IMM_B;
         OP_JAL:  imm_src = IMM_J;
         default: imm_src = IMM_I;
      endcase
   end

   assign mem_req     = out_q.mem_req;
   assign adr_src     = out_q.adr_src;
   assign mem_write   = out_q.mem_write;
   assign reg_write   = out_q.reg_write;
   assign alu_src_a   = out_q.alu_src_a;
   assign alu_src_b   = out_q.alu_src_b;
   assign alu_op      = out_q.alu_op;
   assign result_src  = out_q.result_src;
   assign ir_write    = (state_q == S_FETCH) && mem_ready;
   assign pc_write    = ((state_q == S_FETCH) && mem_ready) ||
                        ((state_q == S_BEQ) && zero) ||
                        (state_q == S_JAL);
   assign illegal_op  = (state_q == S_DECODE) && !legal_op;
   assign mem_timeout = timeout;

endmodule

`default_nettype wire
